multi_channel_counter: RTL and testbench

//  Parametrised N-channel programmable counter. Successor to the single free-running compare counter.

---
 rtl/multi_channel_counter_if.sv | 25 ++
 rtl/multi_channel_counter.sv | 124 ++++++++++++
 tb/tb_multi_channel_counter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_channel_counter_if.sv
// Command port of multi_channel_counter: valid/ready programming bus plus error pulse.
interface multi_channel_counter_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N_CH  = 4
);
    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [CH_W-1:0]  cmd_ch;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_stop;
    logic             cmd_mode;
    logic             cmd_err;

    modport master (
        output cmd_valid, cmd_ch, cmd_op, cmd_stop, cmd_mode,
        input  cmd_ready, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_ch, cmd_op, cmd_stop, cmd_mode,
        output cmd_ready, cmd_err
    );
endinterface

// File: rtl/multi_channel_counter.sv
// N-channel programmable counter: per-channel stop value, one-shot/periodic mode,
// run/halt/clear control via a valid/ready command port, registered count readback.
module multi_channel_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N_CH  = 4,
    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   reset_l,
    input  logic                   en,
    multi_channel_counter_if.slave cmd,
    input  logic [CH_W-1:0]        rd_ch,
    output logic [WIDTH-1:0]       rd_count,
    output logic [N_CH-1:0]        tick,
    output logic [N_CH-1:0]        done,
    output logic [N_CH-1:0]        busy
);
    typedef enum logic [1:0] {StIdle, StRun, StHalt, StDone} ch_st_e;

    localparam logic [1:0] OpStart  = 2'b00;
    localparam logic [1:0] OpStop   = 2'b01;
    localparam logic [1:0] OpClear  = 2'b10;
    localparam logic [1:0] OpResume = 2'b11;

    ch_st_e                       st_q [N_CH];
    ch_st_e                       st_d [N_CH];
    logic [N_CH-1:0][WIDTH-1:0]   ctr_q, ctr_d;
    logic [N_CH-1:0][WIDTH-1:0]   stop_q, stop_d;
    logic [N_CH-1:0]              mode_q, mode_d;
    logic [N_CH-1:0]              tick_q, tick_d;
    logic                         cmd_ready_q, cmd_ready_d;
    logic                         cmd_err_q, cmd_err_d;
    logic [WIDTH-1:0]             rd_count_q, rd_count_d;
    logic                         accept;
    logic                         cmd_oob;

    // Next-state for every channel; an accepted command to a channel overrides its count step.
    always_comb begin
        accept      = cmd.cmd_valid && cmd_ready_q;
        cmd_oob     = 32'(cmd.cmd_ch) >= N_CH;
        cmd_ready_d = !accept;
        cmd_err_d   = accept && cmd_oob;
        for (int i = 0; i < N_CH; i++) begin
            st_d[i]   = st_q[i];
            ctr_d[i]  = ctr_q[i];
            stop_d[i] = stop_q[i];
            mode_d[i] = mode_q[i];
            tick_d[i] = 1'b0;
            if (accept && cmd.cmd_ch == CH_W'(i)) begin
                unique case (cmd.cmd_op)
                    OpStart: begin
                        st_d[i]   = StRun;
                        ctr_d[i]  = '0;
                        stop_d[i] = cmd.cmd_stop;
                        mode_d[i] = cmd.cmd_mode;
                    end
                    OpStop: begin
                        if (st_q[i] == StRun) st_d[i] = StHalt;
                    end
                    OpClear: begin
                        st_d[i]  = StIdle;
                        ctr_d[i] = '0;
                    end
                    OpResume: begin
                        if (st_q[i] == StHalt) st_d[i] = StRun;
                    end
                endcase
            end else if (st_q[i] == StRun && en) begin
                if (ctr_q[i] == stop_q[i]) begin
                    tick_d[i] = 1'b1;
                    // One-shot parks in DONE with ctr left at stop.
                    if (mode_q[i]) ctr_d[i] = '0;
                    else           st_d[i]  = StDone;
                end else begin
                    ctr_d[i] = ctr_q[i] + WIDTH'(1);
                end
            end
        end
    end

    // Readback mux; channel selects with no channel behind them read as zero.
    always_comb begin
        rd_count_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (rd_ch == CH_W'(i)) rd_count_d = ctr_q[i];
        end
    end

    // State registers, asynchronously cleared.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            for (int i = 0; i < N_CH; i++) st_q[i] <= StIdle;
            ctr_q       <= '0;
            stop_q      <= '0;
            mode_q      <= '0;
            tick_q      <= '0;
            cmd_ready_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            rd_count_q  <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) st_q[i] <= st_d[i];
            ctr_q       <= ctr_d;
            stop_q      <= stop_d;
            mode_q      <= mode_d;
            tick_q      <= tick_d;
            cmd_ready_q <= cmd_ready_d;
            cmd_err_q   <= cmd_err_d;
            rd_count_q  <= rd_count_d;
        end
    end

    // Level outputs decoded straight from the state registers.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            done[i] = (st_q[i] == StDone);
            busy[i] = (st_q[i] == StRun);
        end
    end

    assign tick          = tick_q;
    assign rd_count      = rd_count_q;
    assign cmd.cmd_ready = cmd_ready_q;
    assign cmd.cmd_err   = cmd_err_q;
endmodule

// File: tb/tb_multi_channel_counter.sv
// Directed bench for multi_channel_counter: a 4-channel instance for the main behaviour and
// a 5-channel instance so that out-of-range channel selects are reachable.
module tb_multi_channel_counter;
    localparam logic [1:0] OP_START  = 2'b00;
    localparam logic [1:0] OP_STOP   = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_RESUME = 2'b11;

    logic       clk = 1'b0;
    logic       reset_l;
    logic       en;
    logic [1:0] rd_ch;
    logic [7:0] rd_count;
    logic [3:0] tick, done, busy;
    logic [2:0] rd_ch5;
    logic [7:0] rd_count5;
    logic [4:0] tick5, done5, busy5;

    int n_checks = 0;
    int n_fail   = 0;

    multi_channel_counter_if #(.WIDTH(8), .N_CH(4)) cmd_if ();
    multi_channel_counter_if #(.WIDTH(8), .N_CH(5)) cmd_if5 ();

    multi_channel_counter #(.WIDTH(8), .N_CH(4)) u_dut (
        .clk      (clk),
        .reset_l  (reset_l),
        .en       (en),
        .cmd      (cmd_if),
        .rd_ch    (rd_ch),
        .rd_count (rd_count),
        .tick     (tick),
        .done     (done),
        .busy     (busy)
    );

    multi_channel_counter #(.WIDTH(8), .N_CH(5)) u_dut5 (
        .clk      (clk),
        .reset_l  (reset_l),
        .en       (en),
        .cmd      (cmd_if5),
        .rd_ch    (rd_ch5),
        .rd_count (rd_count5),
        .tick     (tick5),
        .done     (done5),
        .busy     (busy5)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one command, wait (bounded) for ready, return just after the accepting edge.
    task automatic send(input int sel, input int ch, input logic [1:0] op,
                        input logic [7:0] stp, input logic md);
        int   waited;
        logic rdy;
        waited = 0;
        if (sel == 0) begin
            cmd_if.cmd_ch   = 2'(ch);
            cmd_if.cmd_op   = op;
            cmd_if.cmd_stop = stp;
            cmd_if.cmd_mode = md;
            cmd_if.cmd_valid = 1'b1;
        end else begin
            cmd_if5.cmd_ch   = 3'(ch);
            cmd_if5.cmd_op   = op;
            cmd_if5.cmd_stop = stp;
            cmd_if5.cmd_mode = md;
            cmd_if5.cmd_valid = 1'b1;
        end
        rdy = (sel == 0) ? cmd_if.cmd_ready : cmd_if5.cmd_ready;
        while (!rdy && waited < 10) begin
            step(1);
            waited++;
            rdy = (sel == 0) ? cmd_if.cmd_ready : cmd_if5.cmd_ready;
        end
        if (!rdy) check("cmd_ready_timeout", 32'(rdy), 32'd1);
        step(1);
        cmd_if.cmd_valid  = 1'b0;
        cmd_if5.cmd_valid = 1'b0;
    endtask

    initial begin
        reset_l = 1'b0;
        en      = 1'b0;
        rd_ch   = '0;
        rd_ch5  = '0;
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_ch     = '0;
        cmd_if.cmd_op     = '0;
        cmd_if.cmd_stop   = '0;
        cmd_if.cmd_mode   = 1'b0;
        cmd_if5.cmd_valid = 1'b0;
        cmd_if5.cmd_ch    = '0;
        cmd_if5.cmd_op    = '0;
        cmd_if5.cmd_stop  = '0;
        cmd_if5.cmd_mode  = 1'b0;

        // Reset state, release between edges, ready rises after the first edge.
        #12;
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_rd_count", 32'(rd_count), 32'h0);
        check("rst_cmd_err", 32'(cmd_if.cmd_err), 32'h0);
        reset_l = 1'b1;
        #1;
        check("rst_ready_before_edge", 32'(cmd_if.cmd_ready), 32'h0);
        step(1);
        check("rst_ready_after_edge", 32'(cmd_if.cmd_ready), 32'h1);
        en = 1'b1;
        step(1);

        // 1: one-shot ch0, stop=3.
        rd_ch = 2'd0;
        send(0, 0, OP_START, 8'd3, 1'b0);
        check("t1_busy", 32'(busy[0]), 32'h1);
        check("t1_ready_drop", 32'(cmd_if.cmd_ready), 32'h0);
        for (int m = 1; m <= 3; m++) begin
            step(1);
            check("t1_rd", 32'(rd_count), 32'(m - 1));
            check("t1_no_tick", 32'(tick[0]), 32'h0);
        end
        step(1);
        check("t1_rd_stop", 32'(rd_count), 32'd3);
        check("t1_tick", 32'(tick[0]), 32'h1);
        check("t1_done", 32'(done[0]), 32'h1);
        check("t1_not_busy", 32'(busy[0]), 32'h0);
        step(1);
        check("t1_tick_pulse", 32'(tick[0]), 32'h0);
        check("t1_done_stays", 32'(done[0]), 32'h1);
        check("t1_rd_holds", 32'(rd_count), 32'd3);

        // 2: periodic ch1, stop=2: ticks every 3 cycles.
        rd_ch = 2'd1;
        send(0, 1, OP_START, 8'd2, 1'b1);
        for (int m = 1; m <= 9; m++) begin
            step(1);
            check("t2_tick", 32'(tick[1]), 32'((m % 3) == 0));
            check("t2_rd", 32'(rd_count), 32'((m - 1) % 3));
            check("t2_busy", 32'(busy[1]), 32'h1);
        end

        // 3: en low for 5 edges with ctr=1 -> next tick 5 cycles late.
        step(1);
        en = 1'b0;
        for (int m = 11; m <= 15; m++) begin
            step(1);
            check("t3_frozen_tick", 32'(tick[1]), 32'h0);
            check("t3_frozen_rd", 32'(rd_count), 32'd1);
        end
        en = 1'b1;
        step(1);
        check("t3_no_early_tick", 32'(tick[1]), 32'h0);
        check("t3_rd_resumed", 32'(rd_count), 32'd1);
        step(1);
        check("t3_late_tick", 32'(tick[1]), 32'h1);
        check("t3_rd", 32'(rd_count), 32'd2);
        send(0, 1, OP_CLEAR, 8'd0, 1'b0);
        check("t3_clear_busy", 32'(busy[1]), 32'h0);
        check("t3_ch0_done_kept", 32'(done[0]), 32'h1);

        // 4: ch2 stop=10, halt at 4, resume, clear from DONE.
        rd_ch = 2'd2;
        send(0, 2, OP_START, 8'd10, 1'b0);
        step(4);
        send(0, 2, OP_STOP, 8'd0, 1'b0);
        check("t4_halt_busy", 32'(busy[2]), 32'h0);
        step(6);
        check("t4_halt_rd", 32'(rd_count), 32'd4);
        check("t4_halt_no_tick", 32'(tick[2]), 32'h0);
        send(0, 2, OP_RESUME, 8'd0, 1'b0);
        check("t4_resume_busy", 32'(busy[2]), 32'h1);
        step(2);
        check("t4_resume_rd", 32'(rd_count), 32'd5);
        step(5);
        check("t4_tick", 32'(tick[2]), 32'h1);
        check("t4_done", 32'(done[2]), 32'h1);
        check("t4_rd_stop", 32'(rd_count), 32'd10);
        step(1);
        send(0, 2, OP_CLEAR, 8'd0, 1'b0);
        check("t4_clear_done", 32'(done[2]), 32'h0);
        step(1);
        check("t4_clear_rd", 32'(rd_count), 32'd0);

        // 5: held cmd_valid -> ready toggles; STOP on idle ch3 has no effect.
        check("t5_ready_initial", 32'(cmd_if.cmd_ready), 32'h1);
        cmd_if.cmd_ch    = 2'd3;
        cmd_if.cmd_op    = OP_STOP;
        cmd_if.cmd_valid = 1'b1;
        for (int m = 1; m <= 4; m++) begin
            step(1);
            check("t5_ready_toggle", 32'(cmd_if.cmd_ready), 32'(m % 2 == 0));
        end
        cmd_if.cmd_valid = 1'b0;
        check("t5_ch3_idle", 32'({done[3], busy[3]}), 32'h0);

        // 5b: out-of-range channel on the 5-channel build.
        send(1, 6, OP_START, 8'd0, 1'b1);
        check("t5_err_pulse", 32'(cmd_if5.cmd_err), 32'h1);
        check("t5_err_no_change", 32'(busy5), 32'h0);
        step(1);
        check("t5_err_clears", 32'(cmd_if5.cmd_err), 32'h0);
        send(1, 4, OP_START, 8'd0, 1'b1);
        check("t5_inrange_no_err", 32'(cmd_if5.cmd_err), 32'h0);
        check("t5_ch4_busy", 32'(busy5), 32'h10);
        rd_ch5 = 3'd7;
        step(1);
        check("t5_rd_oob_zero", 32'(rd_count5), 32'h0);

        // 6: async reset mid-count.
        send(0, 1, OP_START, 8'd0, 1'b1);
        send(0, 3, OP_START, 8'd0, 1'b0);
        rd_ch = 2'd0;
        send(0, 0, OP_START, 8'd50, 1'b1);
        step(3);
        check("t6_pre_tick", 32'(tick), 32'h2);
        check("t6_pre_done", 32'(done), 32'h8);
        check("t6_pre_busy", 32'(busy), 32'h3);
        check("t6_pre_rd", 32'(rd_count), 32'd2);
        #3;
        reset_l = 1'b0;
        #1;
        check("t6_tick", 32'(tick), 32'h0);
        check("t6_done", 32'(done), 32'h0);
        check("t6_busy", 32'(busy), 32'h0);
        check("t6_rd", 32'(rd_count), 32'h0);
        check("t6_ready", 32'(cmd_if.cmd_ready), 32'h0);
        check("t6_busy5", 32'(busy5), 32'h0);
        #2;
        reset_l = 1'b1;
        #1;
        check("t6_ready_before_edge", 32'(cmd_if.cmd_ready), 32'h0);
        step(1);
        check("t6_ready_after_edge", 32'(cmd_if.cmd_ready), 32'h1);
        check("t6_busy_after", 32'(busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
